// File: rtl/pif_ram_dma_pkg.sv
// Shared constants for the PIF work-RAM DMA initiator: RAM geometry and FSM encodings.
package pif_ram_dma_pkg;

  localparam int RAM_AW = 11;
  localparam int RAM_DW = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_WRITE = 3'd1;
  localparam state_t ST_READ  = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/pif_ram_dma_rdbuf.sv
// Two-entry read-return FIFO; a push into a full buffer is only taken when a pop frees the head.
module pif_ram_dma_rdbuf
  import pif_ram_dma_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [RAM_DW-1:0] din,
  output logic [RAM_DW-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [1:0]        count
);

  logic [RAM_DW-1:0] r_mem [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;
  logic              w_do_push;
  logic              w_do_pop;

  // Qualify push/pop against occupancy and expose the status flags.
  always_comb begin
    full      = (r_count == 2'd2);
    empty     = (r_count == 2'd0);
    count     = r_count;
    dout      = r_mem[r_rptr];
    w_do_pop  = pop && !empty;
    w_do_push = push && (!full || w_do_pop);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= din;
        r_wptr        <= ~r_wptr;
      end
      if (w_do_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pif_ram_dma.sv
// Work-RAM bus initiator: moves a commanded number of bytes between byte streams and the 2 KB RAM.
module pif_ram_dma
  import pif_ram_dma_pkg::*;
#(
  parameter int ADDR_W       = RAM_AW,
  parameter int LEN_W        = 12,
  parameter int RD_BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [RAM_DW-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [RAM_DW-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_we,
  output logic [RAM_DW-1:0] ram_data,
  output logic              ram_oe,
  input  logic              ram_valid,
  input  logic [RAM_DW-1:0] ram_q
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_rem;
  logic              r_inflight;

  logic              w_wr_hs;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_last;
  logic              w_drain_ok;
  logic              w_full;
  logic              w_empty;
  logic [1:0]        w_count;
  logic [2:0]        w_outst;
  logic [RAM_DW-1:0] w_head;

  // Handshakes and read-issue throttle; a same-cycle pop frees a slot so rd_ready=1 sustains 1 byte/cycle.
  always_comb begin
    w_wr_hs    = (r_state == ST_WRITE) && wr_valid;
    w_pop      = !w_empty && rd_ready;
    w_outst    = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_issue    = (r_state == ST_READ) && (w_outst < 3'(RD_BUF_DEPTH));
    w_push     = ram_valid && r_inflight;
    w_last     = (r_rem == LEN_W'(1));
    w_drain_ok = !r_inflight && (w_empty || ((w_count == 2'd1) && w_pop));
  end

  // Bus and stream outputs; the RAM port is held at zero whenever no access is made.
  always_comb begin
    cmd_ready   = (r_state == ST_IDLE);
    busy        = (r_state != ST_IDLE);
    done        = (r_state == ST_DONE);
    wr_ready    = (r_state == ST_WRITE);
    ram_we      = w_wr_hs;
    ram_oe      = w_issue;
    ram_address = (w_wr_hs || w_issue) ? r_addr : '0;
    ram_data    = w_wr_hs ? wr_data : '0;
    rd_valid    = !w_empty;
    rd_data     = w_head;
  end

  // Transfer FSM, address/length counters and in-flight read tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_rem      <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_addr <= cmd_addr;
            r_rem  <= cmd_len;
            if (cmd_len == '0)   r_state <= ST_DONE;
            else if (cmd_write)  r_state <= ST_WRITE;
            else                 r_state <= ST_READ;
          end
        end
        ST_WRITE: begin
          if (w_wr_hs) begin
            r_addr <= r_addr + ADDR_W'(1);
            r_rem  <= r_rem - LEN_W'(1);
            if (w_last) r_state <= ST_DONE;
          end
        end
        ST_READ: begin
          if (w_issue) begin
            r_addr <= r_addr + ADDR_W'(1);
            r_rem  <= r_rem - LEN_W'(1);
            if (w_last) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_drain_ok) r_state <= ST_DONE;
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  pif_ram_dma_rdbuf u_rdbuf (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (ram_q),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  logic w_unused;
  assign w_unused = w_full;

endmodule

// File: tb/tb_pif_ram_dma.sv
// Directed self-checking bench for pif_ram_dma with a one-cycle registered RAM model.
module tb_pif_ram_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [10:0] cmd_addr = 11'h000;
  logic [11:0] cmd_len = 12'h000;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_valid = 1'b0, wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid, rd_ready = 1'b0;
  logic        busy, done;
  logic [10:0] ram_address;
  logic        ram_we, ram_oe;
  logic [7:0]  ram_data;
  logic        ram_valid = 1'b0;
  logic [7:0]  ram_q = 8'h00;

  logic [7:0]  mem [0:2047];
  logic        busy_hist [0:4095];
  int cyc = 0, n_checks = 0, n_fail = 0;
  int issued = 0, popped = 0, max_out = 0, both_hi = 0;
  int we_addr_q[$], we_data_q[$], we_cyc_q[$], oe_addr_q[$], oe_cyc_q[$];
  int rd_data_q[$], rd_cyc_q[$], done_q[$];
  int acc;

  always #5 clk = ~clk;

  pif_ram_dma dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done), .ram_address(ram_address), .ram_we(ram_we),
    .ram_data(ram_data), .ram_oe(ram_oe), .ram_valid(ram_valid), .ram_q(ram_q)
  );

  function automatic logic [7:0] init_byte(input int a);
    return 8'(a) ^ 8'h5A;
  endfunction

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  initial for (int i = 0; i < 2048; i++) mem[i] = init_byte(i);

  always @(posedge clk) begin
    if (ram_we) mem[ram_address] <= ram_data;
    ram_valid <= ram_oe;
    ram_q     <= mem[ram_address];
  end

  // Negedge monitor: logs every bus/stream event with its cycle number.
  always @(negedge clk) begin
    if (cyc < 4096) busy_hist[cyc] = busy;
    if (ram_we && ram_oe) both_hi++;
    if (ram_we) begin
      we_addr_q.push_back(int'(ram_address));
      we_data_q.push_back(int'(ram_data));
      we_cyc_q.push_back(cyc);
    end
    if (ram_oe) begin
      oe_addr_q.push_back(int'(ram_address));
      oe_cyc_q.push_back(cyc);
      issued++;
    end
    if (rd_valid && rd_ready) begin
      rd_data_q.push_back(int'(rd_data));
      rd_cyc_q.push_back(cyc);
      popped++;
    end
    if (issued - popped > max_out) max_out = issued - popped;
    if (done) done_q.push_back(cyc);
    cyc++;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    we_addr_q.delete(); we_data_q.delete(); we_cyc_q.delete();
    oe_addr_q.delete(); oe_cyc_q.delete();
    rd_data_q.delete(); rd_cyc_q.delete(); done_q.delete();
    issued = 0; popped = 0; max_out = 0;
  endtask

  function automatic logic ready_for(input int mode, input int c);
    logic [3:0] pat;
    pat = 4'b1001;
    if (mode == 0) return 1'b1;
    return pat[c % 4];
  endfunction

  task automatic do_write(input logic [10:0] a, input logic [11:0] l,
                          input logic [31:0] bytes, output int c);
    int  idx;
    logic hs;
    clear_logs();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = l;
    c = cyc; idx = 0;
    wr_valid = (l != 12'd0);
    wr_data  = bytes[7:0];
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      hs = wr_valid && wr_ready;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (hs) idx++;
      if (idx >= int'(l) || idx >= 4) wr_valid = 1'b0;
      else wr_data = bytes[idx*8 +: 8];
      if (done_q.size() > 0) break;
    end
    wr_valid = 1'b0;
    check_eq("wr_done_seen", done_q.size(), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [10:0] a, input logic [11:0] l,
                         input int mode, output int c);
    clear_logs();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = l;
    c = cyc;
    rd_ready = ready_for(mode, cyc);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      rd_ready = ready_for(mode, cyc);
      if (done_q.size() > 0) break;
    end
    check_eq("rd_done_seen", done_q.size(), 1);
    repeat (2) @(posedge clk);
    #1;
    rd_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] exp6 [6];
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ram_we", ram_we, 0);
    check_eq("rst_ram_oe", ram_oe, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_wr_ready", wr_ready, 0);

    // Gapless 4-byte write at 0x010.
    do_write(11'h010, 12'd4, 32'hA4A3A2A1, acc);
    check_eq("w4_count", we_addr_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("w4_addr%0d", k), qget(we_addr_q, k), 16 + k);
      check_eq($sformatf("w4_data%0d", k), qget(we_data_q, k), 8'hA1 + k);
      check_eq($sformatf("w4_cyc%0d", k), qget(we_cyc_q, k), acc + 1 + k);
    end
    check_eq("w4_done_cyc", qget(done_q, 0), acc + 5);
    check_eq("w4_busy_acc", busy_hist[acc], 0);
    for (int k = 1; k <= 5; k++) check_eq($sformatf("w4_busy%0d", k), busy_hist[acc + k], 1);
    check_eq("w4_busy_after", busy_hist[acc + 6], 0);

    // Full-rate readback.
    do_read(11'h010, 12'd4, 0, acc);
    check_eq("r4_oe_count", oe_cyc_q.size(), 4);
    check_eq("r4_oe_first", qget(oe_cyc_q, 0), acc + 1);
    check_eq("r4_oe_last", qget(oe_cyc_q, 3), acc + 4);
    check_eq("r4_rd_count", rd_data_q.size(), 4);
    for (int k = 0; k < 4; k++) check_eq($sformatf("r4_data%0d", k), qget(rd_data_q, k), 8'hA1 + k);
    check_eq("r4_first_rd_cyc", qget(rd_cyc_q, 0), acc + 3);
    check_eq("r4_done_cyc", qget(done_q, 0), acc + 7);
    check_eq("r4_busy_done", busy_hist[acc + 7], 1);
    check_eq("r4_busy_after", busy_hist[acc + 8], 0);

    // Backpressured 6-byte read.
    exp6[0] = 8'hA1; exp6[1] = 8'hA2; exp6[2] = 8'hA3; exp6[3] = 8'hA4;
    exp6[4] = init_byte(16'h014); exp6[5] = init_byte(16'h015);
    do_read(11'h010, 12'd6, 1, acc);
    check_eq("r6_oe_count", oe_cyc_q.size(), 6);
    check_eq("r6_rd_count", rd_data_q.size(), 6);
    for (int k = 0; k < 6; k++) check_eq($sformatf("r6_data%0d", k), qget(rd_data_q, k), int'(exp6[k]));
    check_eq("r6_outstanding_le2", int'(max_out <= 2), 1);

    // Address wrap on write.
    do_write(11'h7FE, 12'd3, 32'h00332211, acc);
    check_eq("wrap_count", we_addr_q.size(), 3);
    check_eq("wrap_addr0", qget(we_addr_q, 0), 11'h7FE);
    check_eq("wrap_addr1", qget(we_addr_q, 1), 11'h7FF);
    check_eq("wrap_addr2", qget(we_addr_q, 2), 11'h000);

    // Zero-length commands.
    do_write(11'h100, 12'd0, 32'h0, acc);
    check_eq("z_w_we", we_addr_q.size(), 0);
    check_eq("z_w_done_cyc", qget(done_q, 0), acc + 1);
    do_read(11'h100, 12'd0, 0, acc);
    check_eq("z_r_oe", oe_cyc_q.size(), 0);
    check_eq("z_r_done_cyc", qget(done_q, 0), acc + 1);

    // Reset with one read in flight.
    clear_logs();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 11'h010; cmd_len = 12'd4;
    rd_ready = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_eq("mr_busy", busy, 0);
    check_eq("mr_cmd_ready", cmd_ready, 1);
    check_eq("mr_ram_oe", ram_oe, 0);
    check_eq("mr_ram_addr", ram_address, 0);
    check_eq("mr_done", done, 0);
    #1;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("mr_stale_ignored", rd_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("mr_no_done", done_q.size(), 0);

    // Service after reset, also wrap readback.
    do_read(11'h7FE, 12'd3, 0, acc);
    check_eq("wr_rb_count", rd_data_q.size(), 3);
    check_eq("wr_rb0", qget(rd_data_q, 0), 8'h11);
    check_eq("wr_rb1", qget(rd_data_q, 1), 8'h22);
    check_eq("wr_rb2", qget(rd_data_q, 2), 8'h33);
    check_eq("wr_rb_oe_addr2", qget(oe_addr_q, 2), 11'h000);

    check_eq("we_oe_exclusive", both_hi, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #90000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
